// File: rtl/video_scanout_if.sv
`default_nettype none
// ============================================================================
// Module   : video_scanout_if
// Purpose  : Video RAM read port and pixel/sync outputs of the scan-out engine.
// Revision : 1.0  initial release
// ============================================================================
interface video_scanout_if;
  logic [14:0] Base_Add;
  logic [14:0] Video_Add;
  logic [7:0]  Video_Data;
  logic [3:0]  Pixel;
  logic        Blank;
  logic        HSync;
  logic        VSync;
  logic        Frame_Start;

  modport master (
    input  Base_Add,
    input  Video_Data,
    output Video_Add,
    output Pixel,
    output Blank,
    output HSync,
    output VSync,
    output Frame_Start
  );

  modport slave (
    output Base_Add,
    output Video_Data,
    input  Video_Add,
    input  Pixel,
    input  Blank,
    input  HSync,
    input  VSync,
    input  Frame_Start
  );
endinterface
`default_nettype wire

// File: rtl/video_scanout.sv
`default_nettype none
// ============================================================================
// Module   : video_scanout
// Purpose  : Raster timing, video RAM fetch and 4bpp pixel serialiser.
// Revision : 1.0  initial release
// ============================================================================
module video_scanout #(
  parameter int H_ACTIVE       = 256,
  parameter int H_TOTAL        = 342,
  parameter int HS_START       = 280,
  parameter int HS_LEN         = 26,
  parameter int V_ACTIVE       = 192,
  parameter int V_TOTAL        = 262,
  parameter int VS_START       = 216,
  parameter int VS_LEN         = 3,
  parameter int BYTES_PER_LINE = 128
) (
  input  logic            clk,
  input  logic            rst,
  video_scanout_if.master vif
);

  // One spare bit so the sync end positions always fit the counter width.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] C_H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] C_H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] C_HS_ON  = HW'(HS_START);
  localparam logic [HW-1:0] C_HS_OFF = HW'(HS_START + HS_LEN);
  localparam logic [VW-1:0] C_V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] C_V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] C_VS_ON  = VW'(VS_START);
  localparam logic [VW-1:0] C_VS_OFF = VW'(VS_START + VS_LEN);
  localparam logic [14:0]   C_STRIDE = 15'(BYTES_PER_LINE);

  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic [14:0]   line_add_q, line_add_d;
  logic [14:0]   vaddr_q;

  logic          active, hsync_pre, vsync_pre, fstart_pre;

  // Delay lines: index 0 lines up with Video_Add, 1 with Video_Data, 2 with Pixel.
  logic [2:0]    act_q, hs_q, vs_q, fs_q;
  logic [1:0]    odd_q;
  logic [3:0]    pix_lo_q;
  logic [3:0]    pixel_q;

  assign active     = (hc_q < C_H_ACT) && (vc_q < C_V_ACT);
  assign hsync_pre  = (hc_q >= C_HS_ON) && (hc_q < C_HS_OFF);
  assign vsync_pre  = (vc_q >= C_VS_ON) && (vc_q < C_VS_OFF);
  assign fstart_pre = (hc_q == '0) && (vc_q == '0);

  always_comb begin
    hc_d       = hc_q + 1'b1;
    vc_d       = vc_q;
    line_add_d = line_add_q;
    if (hc_q == C_H_LAST) begin
      hc_d = '0;
      if (vc_q == C_V_LAST) begin
        vc_d       = '0;
        line_add_d = vif.Base_Add;
      end else begin
        vc_d = vc_q + 1'b1;
        if (vc_q < C_V_ACT) begin
          line_add_d = line_add_q + C_STRIDE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_q       <= '0;
      vc_q       <= '0;
      line_add_q <= '0;
      vaddr_q    <= '0;
    end else begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      line_add_q <= line_add_d;
      if (active) begin
        vaddr_q <= line_add_q + 15'(hc_q >> 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q    <= '0;
      hs_q     <= '0;
      vs_q     <= '0;
      fs_q     <= '0;
      odd_q    <= '0;
      pix_lo_q <= '0;
      pixel_q  <= '0;
    end else begin
      act_q <= {act_q[1:0], active};
      hs_q  <= {hs_q[1:0], hsync_pre};
      vs_q  <= {vs_q[1:0], vsync_pre};
      fs_q  <= {fs_q[1:0], fstart_pre};
      odd_q <= {odd_q[0], hc_q[0]};
      // Even phase emits the high nibble straight from RAM and keeps the low one.
      if (act_q[1] && !odd_q[1]) begin
        pix_lo_q <= vif.Video_Data[3:0];
      end
      if (!act_q[1]) begin
        pixel_q <= '0;
      end else if (odd_q[1]) begin
        pixel_q <= pix_lo_q;
      end else begin
        pixel_q <= vif.Video_Data[7:4];
      end
    end
  end

  assign vif.Video_Add   = vaddr_q;
  assign vif.Pixel       = pixel_q;
  assign vif.Blank       = ~act_q[2];
  assign vif.HSync       = hs_q[2];
  assign vif.VSync       = vs_q[2];
  assign vif.Frame_Start = fs_q[2];

endmodule
`default_nettype wire

// File: doc/video_scanout.md
Name: video_scanout

Overview:
- Raster scan-out engine on the read side of the 32 KiB video RAM.
- Generates horizontal/vertical timing and drives the RAM video read address.
- Consumes the returned bytes (1-clock synchronous read latency) and serialises them into 4bpp pixels with aligned sync and blank for the DAC/palette stage.
- One pixel per clk; no CPU-side involvement.

Parameters:
- H_ACTIVE, 256, visible pixels per line (even).
- H_TOTAL, 342, clocks per line.
- HS_START, 280, hc value where HSync asserts.
- HS_LEN, 26, HSync width in clocks.
- V_ACTIVE, 192, visible lines.
- V_TOTAL, 262, lines per frame.
- VS_START, 216, vc value where VSync asserts.
- VS_LEN, 3, VSync width in lines.
- BYTES_PER_LINE, 128, address stride per line (H_ACTIVE/2).

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous active-high reset
- Base_Add  in  15  frame start address; sampled once per frame
- Video_Add  out  15  byte address to video RAM read port
- Video_Data  in  8  RAM read data, valid 1 clk after Video_Add
- Pixel  out  4  pixel colour index
- Blank  out  1  1 = outside active area, Pixel forced to 0
- HSync  out  1  active-high horizontal sync
- VSync  out  1  active-high vertical sync
- Frame_Start  out  1  one-clk pulse at hc=0, vc=0 (pipeline-aligned)

Behaviour:
- Reset (async, rst=1):
  - hc=0, vc=0, line_add=0, frame_base=0.
  - Video_Add=0, Pixel=0, Blank=1, HSync=0, VSync=0, Frame_Start=0.
  - Pipeline registers are cleared.
- After reset release:
  - Counting starts on the first clk edge at hc=0, vc=0.
  - Base_Add is sampled at the next frame boundary. The first frame reads from address 0.
- Counters:
  - hc counts 0..H_TOTAL-1, then wraps to 0.
  - When hc wraps, vc increments; vc wraps 0 after V_TOTAL-1.
- Frame base:
  - At hc=H_TOTAL-1 and vc=V_TOTAL-1, frame_base<=Base_Add and line_add<=Base_Add.
  - Base_Add changes at any other time have no effect on the current frame.
- Line address:
  - At hc=H_TOTAL-1 with vc<V_ACTIVE, line_add<=line_add+BYTES_PER_LINE.
  - The addition wraps modulo 2^15, e.g. 0x7FC0+0x80 -> 0x0040.
- Fetch (registered output):
  - Video_Add=line_add+(hc>>1), mod 2^15.
  - It is updated each clk while hc<H_ACTIVE and vc<V_ACTIVE, otherwise it holds its last value.
  - One byte is requested per even hc; the odd-hc address equals the even one (a harmless duplicate read).
- Data capture:
  - The byte returned for an even-hc request is latched into pix_byte.
  - The high nibble (bits 7:4) is output first, the low nibble (bits 3:0) on the next clk.
- Pipeline latency:
  - Pixel for counter position (hc,vc) appears exactly 3 clks after the counters hold (hc,vc): address register, RAM, nibble select.
  - Blank, HSync, VSync and Frame_Start are delayed through a matching 3-stage shift register, so all five outputs change on the same edge.
- Decode (pre-delay):
  - active = hc<H_ACTIVE && vc<V_ACTIVE.
  - HSync = HS_START<=hc<HS_START+HS_LEN.
  - VSync = VS_START<=vc<VS_START+VS_LEN, for the whole line.
  - Frame_Start = hc==0 && vc==0.
- Blank:
  - Blank = !active (delayed).
  - When Blank=1, Pixel=0 regardless of RAM data.
- Reset mid-frame:
  - All state, including the delay lines, clears immediately.
  - No partial sync pulse may persist after rst falls.

Test Plan:
- Reset/idle:
  - Assert rst mid-line with HSync high -> all outputs at reset values asynchronously; HSync=0 before the next clk edge.
- First-pixel latency:
  - RAM model with 1-clk latency, byte at 0x0000=0xA5.
  - Release reset -> Frame_Start=1 and Pixel=0xA on the same clk 3 edges after the counters reach 0/0; Pixel=0x5 on the next clk; Blank=0 on both.
- Line stride:
  - Base_Add=0x1000 for the next frame -> line 0 reads 0x1000..0x107F; line 1 starts at 0x1080; line 191 ends at 0x1000+191*128+127=0x6FFF.
- Address wrap:
  - Base_Add=0x7F00 -> line 2 begins at 0x0000 (0x7F00+0x100 wraps).
  - No X/overflow on Video_Add.
- Timing:
  - Count over 2 frames -> HSync high for 26 clks per line, starting at pipelined hc=280.
  - VSync high for lines 216..218 only.
  - Frame period 342*262=89604 clks.
  - Blank=1 for hc>=256 or vc>=192, with Pixel=0 throughout blanking even when RAM returns 0xFF.
- Base_Add change mid-frame:
  - Change Base_Add at vc=100 -> current frame's addresses unaffected; the new base takes effect on the following frame's line 0.
